mips_run_controller: RTL and testbench

Synthesizable run controller that generalises the fixed reset-then-run sequence around the MIPS core: it holds the core in reset for a parametrised number of cycles, runs it for a bounded window, detects halt, and compresses the register-writeback stream into a signature for pass/fail. It sits between the top-level clock/reset and `main_2`-class cores, and drives the core's reset. The same block serves both the bench and on-board self-test.

---
 rtl/mips_run_pkg.sv | 15 +
 rtl/mips_wb_signature.sv | 49 ++++
 rtl/mips_run_controller.sv | 131 +++++++++++++
 tb/tb_mips_run_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_run_pkg.sv
// Shared types and constants for the MIPS run controller.
// State encoding, signature seed and register-index width.
package mips_run_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } run_state_e;

    localparam int unsigned RegIdxW = 5;
    localparam int unsigned SigSeed = 0;

endpackage

// File: rtl/mips_wb_signature.sv
// Rotate-xor accumulator over the core writeback stream, plus a writeback counter.
// sig_next exposes the value the accumulator takes on the coming edge.
module mips_wb_signature
    import mips_run_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic [RegIdxW-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic [DATA_W-1:0]  signature,
    output logic [DATA_W-1:0]  sig_next,
    output logic [CNT_W-1:0]   wb_count
);

    logic [DATA_W-1:0] sig_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    always_comb begin
        sig_next = sig_q;
        cnt_d    = cnt_q;
        if (clear) begin
            sig_next = DATA_W'(SigSeed);
            cnt_d    = '0;
        end else if (enable) begin
            sig_next = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ wb_data ^ DATA_W'(wb_addr);
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sig_q <= '0;
            cnt_q <= '0;
        end else begin
            sig_q <= sig_next;
            cnt_q <= cnt_d;
        end
    end

    assign signature = sig_q;
    assign wb_count  = cnt_q;

endmodule

// File: rtl/mips_run_controller.sv
// Reset-hold / bounded-run sequencer for a MIPS core with writeback signature check.
// Define MIPS_RUN_HALT_EN to let core_halt end the run and to report timeout.
module mips_run_controller
    import mips_run_pkg::*;
#(
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       CNT_W        = 16,
    parameter int unsigned       RESET_CYCLES = 10,
    parameter int unsigned       RUN_CYCLES   = 100,
    parameter logic [DATA_W-1:0] EXPECTED_SIG = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               core_halt,
    input  logic               wb_en,
    input  logic [RegIdxW-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               core_reset,
    output logic               running,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   wb_count,
    output logic [DATA_W-1:0]  signature
);

`ifdef MIPS_RUN_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    // Counts 0..RESET_CYCLES so RUN is entered RESET_CYCLES+1 edges after start.
    localparam int unsigned HoldW = $clog2(RESET_CYCLES + 1);

    run_state_e        state_q, state_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              timeout_q, timeout_d;
    logic              pass_q, pass_d;
    logic              sig_clear;
    logic              sig_en;
    logic              halt_seen;
    logic [DATA_W-1:0] sig_next;

    assign halt_seen = HaltEn & core_halt;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cyc_d     = cyc_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        sig_clear = 1'b0;
        sig_en    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StHold;
                    hold_d    = '0;
                    cyc_d     = '0;
                    timeout_d = 1'b0;
                    pass_d    = 1'b0;
                    sig_clear = 1'b1;
                end
            end
            StHold: begin
                if (hold_q == HoldW'(RESET_CYCLES)) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StRun: begin
                cyc_d  = cyc_q + CNT_W'(1);
                sig_en = wb_en;
                // A writeback on the final edge is already folded into sig_next.
                if (halt_seen) begin
                    state_d = StDone;
                    pass_d  = (sig_next == EXPECTED_SIG);
                end else if (cyc_q == CNT_W'(RUN_CYCLES - 1)) begin
                    state_d   = StDone;
                    timeout_d = HaltEn;
                    pass_d    = (sig_next == EXPECTED_SIG) & ~HaltEn;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            cyc_q     <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cyc_q     <= cyc_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
        end
    end

    mips_wb_signature #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_sig (
        .clock     (clock),
        .reset     (reset),
        .clear     (sig_clear),
        .enable    (sig_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .signature (signature),
        .sig_next  (sig_next),
        .wb_count  (wb_count)
    );

    assign core_reset  = (state_q == StIdle) || (state_q == StHold);
    assign running     = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed bench for mips_run_controller with a scoreboard of expected run results.
module tb_mips_run_controller;

    localparam int unsigned DataW       = 32;
    localparam int unsigned CntW        = 16;
    localparam int unsigned ResetCycles = 10;
    localparam int unsigned RunCycles   = 100;
    localparam logic [31:0] ExpSig      = 32'h9;

`ifdef MIPS_RUN_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    typedef struct {
        int          cyc;
        int          wbc;
        logic [31:0] sig;
        logic        pass;
        logic        timeout;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             core_halt = 1'b0;
    logic             wb_en = 1'b0;
    logic [4:0]       wb_addr = '0;
    logic [DataW-1:0] wb_data = '0;
    logic             core_reset, running, done, pass, timeout;
    logic [CntW-1:0]  cycle_count, wb_count;
    logic [DataW-1:0] signature;

    mips_run_controller #(
        .DATA_W       (DataW),
        .CNT_W        (CntW),
        .RESET_CYCLES (ResetCycles),
        .RUN_CYCLES   (RunCycles),
        .EXPECTED_SIG (ExpSig)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .core_halt   (core_halt),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .core_reset  (core_reset),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .wb_count    (wb_count),
        .signature   (signature)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fold(input logic [31:0] s, input logic [4:0] a,
                                         input logic [31:0] d);
        return {s[30:0], s[31]} ^ d ^ {27'b0, a};
    endfunction

    // Writeback stimulus for RUN cycle k (k-th RUN edge).
    function automatic void wb_plan(input int pat, input int k, output logic en,
                                    output logic [4:0] a, output logic [31:0] d);
        en = 1'b0;
        a  = '0;
        d  = '0;
        if (pat == 0) begin
            if (k == 1) begin
                en = 1'b1; a = 5'd1; d = 32'h5;
            end else if (k == 2) begin
                en = 1'b1; a = 5'd2; d = 32'h3;
            end
        end else if (k % 2 == 0) begin
            en = 1'b1;
            a  = 5'(k);
            d  = (32'(k) * 32'h0101_0101) ^ 32'hdead_beef;
        end
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
        chk({tag, "_running"}, 64'(running), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
        chk({tag, "_wb_count"}, 64'(wb_count), 64'd0);
        chk({tag, "_signature"}, 64'(signature), 64'd0);
    endtask

    task automatic check_result(input string tag, input exp_t e);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_running"}, 64'(running), 64'd0);
        chk({tag, "_cycle_count"}, 64'(cycle_count), 64'(e.cyc));
        chk({tag, "_wb_count"}, 64'(wb_count), 64'(e.wbc));
        chk({tag, "_signature"}, 64'(signature), 64'(e.sig));
        chk({tag, "_pass"}, 64'(pass), 64'(e.pass));
        chk({tag, "_timeout"}, 64'(timeout), 64'(e.timeout));
    endtask

    // halt_at/start_at/reset_at of 0 mean "never".
    task automatic run_seq(input string tag, input int pat, input int halt_at,
                           input int start_at, input int reset_at);
        exp_t        e;
        logic        en;
        logic [4:0]  a;
        logic [31:0] d;
        int          end_k;
        int          done_k;

        if (reset_at == 0) begin
            end_k = (HaltEn && halt_at >= 1 && halt_at <= int'(RunCycles)) ? halt_at
                                                                           : int'(RunCycles);
            e.sig = '0;
            e.wbc = 0;
            for (int k = 1; k <= end_k; k++) begin
                wb_plan(pat, k, en, a, d);
                if (en) begin
                    e.sig = fold(e.sig, a, d);
                    e.wbc++;
                end
            end
            e.cyc     = end_k;
            e.timeout = HaltEn && (halt_at != end_k);
            e.pass    = (e.sig == ExpSig) && !e.timeout;
            sb_q.push_back(e);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        check_idle({tag, "_cleared"});

        // Core inputs and start are noise while held in reset.
        for (int i = 1; i <= int'(ResetCycles); i++) begin
            start     = (i == 3);
            wb_en     = 1'b1;
            core_halt = 1'b1;
            wb_addr   = 5'd7;
            wb_data   = 32'hffff_0000;
            tick();
            chk($sformatf("%s_hold%0d", tag, i), 64'({core_reset, running}), 64'b10);
        end
        start = 1'b0;
        tick();
        chk({tag, "_run_entry"}, 64'({core_reset, running}), 64'b01);

        done_k = -1;
        for (int k = 1; k <= int'(RunCycles) + 5; k++) begin
            wb_plan(pat, k, en, a, d);
            wb_en     = en;
            wb_addr   = a;
            wb_data   = d;
            core_halt = (k == halt_at);
            start     = (k == start_at);
            reset     = (k == reset_at);
            tick();
            if (k == reset_at) begin
                reset     = 1'b0;
                wb_en     = 1'b0;
                core_halt = 1'b0;
                start     = 1'b0;
                check_idle({tag, "_midrun_reset"});
                return;
            end
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        wb_en     = 1'b0;
        core_halt = 1'b0;
        start     = 1'b0;

        e = sb_q.pop_front();
        chk({tag, "_done_edge"}, 64'(done_k), 64'(e.cyc));
        check_result(tag, e);

        // Activity after completion must not move anything.
        wb_en     = 1'b1;
        core_halt = 1'b1;
        wb_addr   = 5'd3;
        wb_data   = 32'h1234_5678;
        repeat (3) tick();
        wb_en     = 1'b0;
        core_halt = 1'b0;
        check_result({tag, "_hold_done"}, e);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_idle("reset");

        run_seq("halt5", 0, 5, 0, 0);
        run_seq("nohalt", 0, 0, 20, 0);
        run_seq("lasthalt", 1, int'(RunCycles), 0, 0);
        run_seq("rst40", 0, 0, 0, 40);
        run_seq("rerun", 0, 5, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
